// File: rtl/reg_slice_ctrl.sv
// reg_slice_ctrl: control FSM for a two-entry register slice (skid buffer).
// The handshake outputs are decoded from the registered state only. This
// keeps s_ready independent of m_ready, and m_valid independent of s_valid.
// The FSM steers the payload flop clock enables and the main-flop D mux.
// It also counts backpressure cycles and flags upstream valid withdrawal.
module reg_slice_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       main_ce,
    output logic [1:0]       skid_ce,
    output logic             main_src_skid,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // Payload flop clock-enable encoding
    localparam logic [1:0] CE_LOAD = 2'b10;
    localparam logic [1:0] CE_HOLD = 2'b01;
    localparam logic [1:0] CE_INV  = 2'b00;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic             s_ready_s;
    logic             m_valid_s;
    logic [1:0]       occ_s;
    logic             in_s;
    logic             out_s;
    logic [1:0]       main_ce_s;
    logic [1:0]       skid_ce_s;
    logic             sel_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             stall_prev_r;
    logic             proto_err_r;

    // State register. A reset discards any held beats without draining them.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Decode the handshake and occupancy from the registered state only. Everything is low while in reset.
    always_comb begin
        s_ready_s = 1'b0;
        m_valid_s = 1'b0;
        occ_s     = 2'd0;
        if (rstn) begin
            case (state_r)
                ST_EMPTY: begin
                    s_ready_s = 1'b1;
                end
                ST_BUSY: begin
                    s_ready_s = 1'b1;
                    m_valid_s = 1'b1;
                    occ_s     = 2'd1;
                end
                ST_FULL: begin
                    m_valid_s = 1'b1;
                    occ_s     = 2'd2;
                end
                default: begin
                    s_ready_s = 1'b0;
                    m_valid_s = 1'b0;
                    occ_s     = 2'd0;
                end
            endcase
        end else begin
            s_ready_s = 1'b0;
            m_valid_s = 1'b0;
            occ_s     = 2'd0;
        end
    end

    assign in_s  = s_valid & s_ready_s;
    assign out_s = m_valid_s & m_ready;

    // Next-state logic. The illegal encoding recovers to EMPTY.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (in_s && !out_s) begin
                    state_nxt_s = ST_FULL;
                end else if (!in_s && out_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (out_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Datapath steering. Dead slots are invalidated. The skid beat moves into main when FULL drains.
    always_comb begin
        main_ce_s = CE_INV;
        skid_ce_s = CE_INV;
        sel_s     = 1'b0;
        if (rstn) begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_s) begin
                        main_ce_s = CE_LOAD;
                    end else begin
                        main_ce_s = CE_INV;
                    end
                end
                ST_BUSY: begin
                    if (in_s && out_s) begin
                        main_ce_s = CE_LOAD;
                    end else if (in_s) begin
                        main_ce_s = CE_HOLD;
                        skid_ce_s = CE_LOAD;
                    end else if (out_s) begin
                        main_ce_s = CE_INV;
                    end else begin
                        main_ce_s = CE_HOLD;
                    end
                end
                ST_FULL: begin
                    if (out_s) begin
                        main_ce_s = CE_LOAD;
                        sel_s     = 1'b1;
                        skid_ce_s = CE_INV;
                    end else begin
                        main_ce_s = CE_HOLD;
                        skid_ce_s = CE_HOLD;
                    end
                end
                default: begin
                    main_ce_s = CE_INV;
                    skid_ce_s = CE_INV;
                    sel_s     = 1'b0;
                end
            endcase
        end else begin
            main_ce_s = CE_INV;
            skid_ce_s = CE_INV;
            sel_s     = 1'b0;
        end
    end

    // Saturating count of cycles where the consumer holds off a valid beat
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (m_valid_s && !m_ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Remember last cycle's upstream stall. A valid dropped right after a stall is a sticky error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_prev_r <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            stall_prev_r <= s_valid & ~s_ready_s;
            proto_err_r  <= proto_err_r | (stall_prev_r & ~s_valid);
        end
    end

    assign s_ready       = s_ready_s;
    assign m_valid       = m_valid_s;
    assign occupancy     = occ_s;
    assign main_ce       = main_ce_s;
    assign skid_ce       = skid_ce_s;
    assign main_src_skid = sel_s;
    assign stall_cnt     = stall_cnt_r;
    assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_reg_slice_ctrl.sv
// tb_reg_slice_ctrl: scoreboard bench for the register-slice controller.
// A behavioural payload datapath is driven by the DUT's enables. The
// reference model is a beat count plus a FIFO of accepted data. A monitor
// pops the FIFO on every output handshake and compares the payload.
module tb_reg_slice_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rstn;
    logic             s_valid;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic [1:0]       main_ce;
    logic [1:0]       skid_ce;
    logic             main_src_skid;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic             proto_err;

    logic [7:0] s_data;
    logic [7:0] main_q;
    logic [7:0] skid_q;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] sb_q[$];
    int         m_occ   = 0;
    int         m_stall = 0;
    bit         m_perr  = 1'b0;
    bit         m_prev  = 1'b0;

    reg_slice_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .main_ce       (main_ce),
        .skid_ce       (skid_ce),
        .main_src_skid (main_src_skid),
        .occupancy     (occupancy),
        .stall_cnt     (stall_cnt),
        .proto_err     (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Payload flops steered by the DUT enables; invalidate makes the slot unknown
    always @(posedge clk) begin
        case (main_ce)
            2'b10, 2'b11: main_q <= main_src_skid ? skid_q : s_data;
            2'b01:        main_q <= main_q;
            default:      main_q <= 8'bx;
        endcase
        case (skid_ce)
            2'b10, 2'b11: skid_q <= s_data;
            2'b01:        skid_q <= skid_q;
            default:      skid_q <= 8'bx;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Output monitor: every consumer handshake must present the oldest accepted beat
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("data_out", {24'd0, main_q}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    // One clock of stimulus: drive, check against the model, advance the model
    task automatic step(input logic r, input logic sv, input logic mr);
        bit         exp_sr;
        bit         exp_mv;
        bit         acc;
        bit         dep;
        logic [1:0] exp_mce;
        logic [1:0] exp_sce;
        rstn    = r;
        s_valid = sv;
        m_ready = mr;
        s_data  = 8'($urandom_range(0, 255));
        #2;
        exp_sr = r && (m_occ < 2);
        exp_mv = r && (m_occ > 0);
        acc    = sv && exp_sr;
        dep    = exp_mv && mr;
        exp_mce = 2'b00;
        exp_sce = 2'b00;
        if (r) begin
            if (m_occ == 0)      exp_mce = acc ? 2'b10 : 2'b00;
            else if (m_occ == 1) exp_mce = (acc && dep) ? 2'b10 : (acc ? 2'b01 : (dep ? 2'b00 : 2'b01));
            else                 exp_mce = dep ? 2'b10 : 2'b01;
            if (m_occ == 2)              exp_sce = dep ? 2'b00 : 2'b01;
            else if (m_occ == 1 && acc && !dep) exp_sce = 2'b10;
        end
        chk("s_ready",   {31'd0, s_ready},  {31'd0, exp_sr});
        chk("m_valid",   {31'd0, m_valid},  {31'd0, exp_mv});
        chk("occupancy", {30'd0, occupancy}, r ? 32'(m_occ) : 32'd0);
        chk("main_ce",   {30'd0, main_ce},  {30'd0, exp_mce});
        chk("skid_ce",   {30'd0, skid_ce},  {30'd0, exp_sce});
        chk("sel",       {31'd0, main_src_skid}, {31'd0, (r && m_occ == 2 && dep)});
        chk("stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'(m_stall));
        chk("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
        if (!r) begin
            m_occ   = 0;
            m_stall = 0;
            m_perr  = 1'b0;
            m_prev  = 1'b0;
            sb_q.delete();
        end else begin
            if (acc) sb_q.push_back(s_data);
            m_occ = m_occ + int'(acc) - int'(dep);
            if (exp_mv && !mr && m_stall < CNT_MAX) m_stall++;
            if (m_prev && !sv) m_perr = 1'b1;
            m_prev = sv && !exp_sr;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn    = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b0;
        s_data  = 8'd0;
        @(posedge clk);
        #1;
        // Reset held with upstream valid, then first live cycle
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);

        // Full-rate streaming
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
        chk("stream_stall", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'd0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // Backpressure into FULL, then drain
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        chk("bp_stall", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'd3);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // Saturation of the stall counter
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("sat_stall", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'(CNT_MAX));
        step(1'b1, 1'b0, 1'b1);

        // Protocol error from FULL, then reset while full
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("perr_set", {31'd0, proto_err}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("perr_clear", {31'd0, proto_err}, 32'd0);
        step(1'b1, 1'b0, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
